// File: rtl/hash_des_stream.sv
`default_nettype none
// ============================================================================
// Module   : hash_des_stream
// Purpose  : Streaming DES-S5 byte hash. Absorbs len_in bytes over a
//            valid/ready stream, applies ROUNDS rounds per byte to a 32-bit
//            nibble state, runs a length-dependent final round and holds the
//            digest until acknowledged.
// Options  : HASH_DES_STREAM_ITERATIVE_EN - reuse one round per clock through
//            a ROUND state instead of chaining ROUNDS rounds combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module hash_des_stream #(
    parameter int          ROUNDS = 4,
    parameter int          LEN_W  = 64,
    parameter logic [31:0] IV     = 32'h4B71DF03
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_in,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             digest_valid,
    output logic [31:0]      digest,
    input  logic             digest_ack
);

    // DES S5, row-major (row = {in[5],in[0]}), column 0 of each row in the MSBs
    localparam logic [255:0] S5_TABLE =
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

`ifdef HASH_DES_STREAM_ITERATIVE_EN
    localparam int RC_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_ROUND  = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;
`endif

    function automatic logic [3:0] s5(input logic [5:0] a);
        logic [5:0] idx;
        idx = {a[5], a[0], a[4:1]};
        return S5_TABLE[255 - 4*idx -: 4];
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
        logic [7:0] t;
        t = {x, x} << n;
        return t[7:4];
    endfunction

    // h'[i] = rotl4(h[(i+1) mod 8] ^ s, i/2), nibble 0 in the MSBs
    function automatic logic [31:0] hash_round(input logic [31:0] h, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[31-4*i -: 4] = rotl4(h[31-4*((i+1)%8) -: 4] ^ s, 2'(i/2));
        end
        return r;
    endfunction

    // Length-dependent closing round: each length byte picks its own S-value
    function automatic logic [31:0] final_round(input logic [31:0] h, input logic [63:0] c);
        logic [31:0] r;
        logic [7:0]  ci;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ci  = c[63-8*i -: 8];
            idx = {ci[7]^ci[1], ci[3], ci[2], ci[5]^ci[0], ci[4], ci[6]};
            r[31-4*i -: 4] = rotl4(h[31-4*((i+1)%8) -: 4] ^ s5(idx), 2'(i/2));
        end
        return r;
    endfunction

    function automatic logic [3:0] byte_sval(input logic [7:0] m);
        return s5({m[3]^m[2], m[1], m[0], m[7], m[6], m[5]^m[4]});
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_h;
    logic [LEN_W-1:0]   r_remaining;
    logic [63:0]        r_c;
    logic [31:0]        r_digest;
    logic [3:0]         w_s;
    logic               w_start_ok;
    logic               w_xfer;
    logic               w_last;
    logic               w_len_zero;
    logic [31:0]        w_h_absorb;

    assign in_ready     = (r_state == ST_ABSORB);
    assign busy         = (r_state != ST_IDLE);
    assign digest_valid = (r_state == ST_DONE);
    assign digest       = r_digest;

    assign w_s        = byte_sval(in_data);
    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_remaining == LEN_ONE);
    assign w_len_zero = (len_in == '0);

`ifdef HASH_DES_STREAM_ITERATIVE_EN
    logic [3:0]      r_s;
    logic [RC_W-1:0] r_rcnt;
    logic [31:0]     w_h_step;
    logic            w_round_last;

    // One shared round: fresh S-value on the accept cycle, held S-value in ROUND
    assign w_h_step     = hash_round(r_h, (r_state == ST_ROUND) ? r_s : w_s);
    assign w_h_absorb   = w_h_step;
    assign w_round_last = (r_rcnt == RC_W'(1));
`else
    logic [31:0] w_chain [0:ROUNDS];

    assign w_chain[0] = r_h;
    for (genvar g = 0; g < ROUNDS; g++) begin : g_chain
        assign w_chain[g+1] = hash_round(w_chain[g], w_s);
    end
    assign w_h_absorb = w_chain[ROUNDS];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_len_zero ? ST_FINAL : ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (w_xfer) begin
`ifdef HASH_DES_STREAM_ITERATIVE_EN
                    if (ROUNDS > 1) begin
                        w_state_nxt = ST_ROUND;
                    end else if (w_last) begin
                        w_state_nxt = ST_FINAL;
                    end
`else
                    if (w_last) begin
                        w_state_nxt = ST_FINAL;
                    end
`endif
                end
            end
`ifdef HASH_DES_STREAM_ITERATIVE_EN
            ST_ROUND: begin
                if (w_round_last) begin
                    w_state_nxt = (r_remaining == '0) ? ST_FINAL : ST_ABSORB;
                end
            end
`endif
            ST_FINAL: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = w_len_zero ? ST_FINAL : ST_ABSORB;
                end else if (digest_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hash state, length bookkeeping and digest capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h         <= IV;
            r_remaining <= '0;
            r_c         <= '0;
            r_digest    <= '0;
`ifdef HASH_DES_STREAM_ITERATIVE_EN
            r_s         <= '0;
            r_rcnt      <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_h         <= IV;
                r_remaining <= len_in;
                r_c         <= 64'(len_in);
            end else if (w_xfer) begin
                r_h         <= w_h_absorb;
                r_remaining <= r_remaining - LEN_ONE;
`ifdef HASH_DES_STREAM_ITERATIVE_EN
                r_s         <= w_s;
                r_rcnt      <= RC_W'(ROUNDS - 1);
            end else if (r_state == ST_ROUND) begin
                r_h         <= w_h_step;
                r_rcnt      <= r_rcnt - RC_W'(1);
`endif
            end
            if (r_state == ST_FINAL) begin
                r_digest <= final_round(r_h, r_c);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hash_des_stream.md
# hash_des_stream

Parametrised streaming successor of the DES-S-box byte hash. It absorbs a message of `len_in` bytes over a valid/ready byte stream and applies `ROUNDS` S-box rounds per byte to a 32-bit nibble state. It then runs the length-dependent final round and holds the 32-bit digest until the consumer acknowledges it. It sits between the byte-stream source and the digest consumer in the hashing subsystem.

## Interface
Parameters:
- `ROUNDS`, default 4: rounds applied per message byte; must be ≥1.
- `LEN_W`, default 64: width of `len_in`; must be a multiple of 8 in 8..64.
- `IV`, default 32'h4B71DF03: initial state; nibble h[i] = IV[31-4i -: 4].

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a new message; sampled in IDLE and DONE only.
- `len_in` in LEN_W: message length in bytes; captured when start is accepted.
- `in_valid` in 1: byte available.
- `in_data` in 8: message byte.
- `in_ready` out 1: block can take a byte this cycle.
- `busy` out 1: high in every state except IDLE.
- `digest_valid` out 1: digest is valid and held.
- `digest` out 32: digest {h'0..h'7}, with h'0 in the MSBs.
- `digest_ack` in 1: consumer has taken the digest.

## Operation
- States: IDLE, ABSORB, ROUND (iterative build only), FINAL, DONE.
- Start accepted (IDLE or DONE, `start`=1):
  - h ← IV, remaining ← len_in, C ← len_in zero-extended to 64 bits.
  - Go to ABSORB, or to FINAL if len_in=0.
- Byte transfer occurs when `in_valid && in_ready`. Any `in_data` outside a transfer is ignored.
- Per-byte S-value:
  - M6 = {M[3]^M[2], M[1], M[0], M[7], M[6], M[5]^M[4]}; s = S5(M6).
  - S5 is the DES S5 table: row = {in[5],in[0]}, column = in[4:1].
  - s is constant for all ROUNDS rounds of that byte.
- Round: h'[i] = rotl4(h[(i+1) mod 8] ^ s, ⌊i/2⌋), i=0..7, so rotate amounts are 0,0,1,1,2,2,3,3.
- In ABSORB, each transfer applies ROUNDS rounds and decrements remaining. When remaining reaches 0, go to FINAL.
- FINAL:
  - Ci = C[63-8i -: 8].
  - idx_i = {Ci[7]^Ci[1], Ci[3], Ci[2], Ci[5]^Ci[0], Ci[4], Ci[6]}.
  - h'[i] = rotl4(h[(i+1) mod 8] ^ S5(idx_i), ⌊i/2⌋).
  - `digest` ← {h'0..h'7} is registered; go to DONE.
- DONE:
  - `digest_valid`=1 and `digest` stable until `digest_ack`=1, then go to IDLE.
  - `start` in DONE acts as ack plus a new start, going to ABSORB or FINAL directly.
- `start` in ABSORB, ROUND or FINAL is ignored.
- `digest_ack` outside DONE is ignored.
- Remaining counter is LEN_W wide; no wrap, because decrement only occurs while remaining>0.
- `in_ready` = (state==ABSORB). It is 0 in IDLE, FINAL and DONE, so extra bytes are never consumed.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `digest_valid`=0, `digest`=0, state IDLE.
- Asynchronous reset mid-message discards all state immediately.
- Non-iterative build:
  - 1 byte per cycle; `in_ready` continuously high in ABSORB.
  - Last byte accepted at edge E: FINAL during cycle E+1; `digest_valid` rises after edge E+1.
- Iterative build:
  - Round 1 is applied at the accept edge E; rounds 2..ROUNDS at edges E+1..E+ROUNDS-1 (state ROUND).
  - `in_ready`=0 for ROUNDS-1 cycles, so throughput is 1 byte per ROUNDS cycles.
  - ROUNDS=1 is cycle-identical to the non-iterative build.
- len_in=0: start at edge S, `digest_valid` after edge S+1.
- `digest_valid` falls on the edge that samples `digest_ack`.
- `digest` keeps its last value until the next FINAL.

## Configuration
- `HASH_DES_STREAM_ITERATIVE_EN` defined:
  - One hashRound instance is reused, one round per clock, through the ROUND state.
  - Area-optimised.
- Undefined:
  - ROUNDS rounds are chained combinationally and applied in the accept cycle.
  - No ROUND state.
- Digest values are identical in both builds; only `in_ready` timing differs.

## Test plan
- Reset: assert rst_n=0 mid-ABSORB → `in_ready`/`busy`/`digest_valid`=0 and `digest`=0 asynchronously; state IDLE after release.
- Empty message: start with len_in=0, default params → `digest`=32'h956F7883, `digest_valid` one cycle after start.
- Stream with backpressure:
  - len_in=5, random in_valid gaps, ROUNDS=4 → digest matches the bit-accurate model.
  - Exactly 5 transfers; a 6th presented byte is not accepted (`in_ready`=0).
- Iterative build, ROUNDS=4, in_valid held high for 3 bytes → `in_ready` pattern 1,0,0,0 per byte; digest equals the non-iterative result for the same bytes.
- DONE handling:
  - Hold `digest_ack`=0 for 10 cycles → `digest` stable and `digest_valid`=1.
  - `start`=1 with len_in=0 in DONE → new digest 32'h956F7883 after one cycle, no IDLE cycle.
- Ignored control: start pulses during ABSORB and `digest_ack` pulses in IDLE → no state, counter or digest change.
